map_lookup_match: RTL and testbench
===================================

# map_lookup_match

Downstream of the five-tuple key extractor in the host-input frame-resolution/mapping path. Takes one extracted lookup request per frame and produces a 14-bit flow ID and a hit flag:
- **Unfragmented TCP/UDP IPv4 and first fragments:** resolved by a sequential search of a software-configured match table.
- **Non-first fragments:** resolved by a small fragment cache keyed on the IPv4 identification.

The result feeds the TSN tag/mapping stage.

## Interface
Parameters:
- ENTRY_NUM, 16: match-table entries, power of two.
- ADDR_W, 4: log2(ENTRY_NUM).
- FRAG_NUM, 4: fragment-cache entries, power of two.
- FLOWID_W, 14: flow ID width.

Ports:
- i_clk  in  1  sole clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- iv_5tuple_data  in  104  {proto[103:96], sip[95:64], dip[63:32], sport[31:16], dport[15:0]}.
- i_5tuple_data_wr  in  1  one-cycle request strobe; all request inputs are valid with it.
- iv_identification  in  16  IPv4 identification.
- i_first_fragment  in  1  fragment offset == 0.
- i_ip_flag  in  1  ethertype 0x0800.
- i_tcp_or_udp_flag  in  1  protocol is 6 or 17.
- i_standardpkt_tsnpkt_flag  in  1  frame class, passed through.
- i_table_wr  in  1  table config write strobe.
- iv_table_waddr  in  ADDR_W  entry index.
- iv_table_wdata  in  104+FLOWID_W+1  {valid, key[103:0], flow_id}.
- ov_flow_id  out  FLOWID_W  result, 0 on miss.
- o_hit  out  1  lookup hit.
- o_lookup_wr  out  1  one-cycle result strobe.
- o_standardpkt_tsnpkt_flag  out  1  latched flag, updated with o_lookup_wr.
- o_drop_err  out  1  one-cycle pulse when a request is discarded.

## Operation
States:
- **IDLE_S.** On i_5tuple_data_wr, latch every request input, then take exactly one of these:
  - !i_ip_flag, or (i_first_fragment && !i_tcp_or_udp_flag): result is a miss; o_lookup_wr is issued directly; stay in IDLE_S.
  - i_ip_flag && i_first_fragment && i_tcp_or_udp_flag: go to SEARCH_S with idx=0.
  - i_ip_flag && !i_first_fragment: go to FRAG_SEARCH_S with idx=0.
- **SEARCH_S.**
  - Per cycle, compare entry[idx] (valid && key == latched key).
  - Match: emit hit with the entry's flow_id, write {identification, flow_id} into the fragment cache at wr_ptr, wr_ptr++ (wraps mod FRAG_NUM), go to IDLE_S.
  - No match and idx == ENTRY_NUM-1: emit miss, go to IDLE_S. Otherwise idx++.
- **FRAG_SEARCH_S.**
  - Per cycle, compare cache[idx] (valid && id == latched identification).
  - Match: emit hit with the cached flow_id. The cache is not updated.
  - No match and idx == FRAG_NUM-1: emit miss. Otherwise idx++.
  - Because entries are scanned upward from idx 0, the lowest matching index wins.
- **Config write.** i_table_wr writes the entry at the clock edge and is accepted in every state. A search comparing the same index in that cycle uses the pre-write contents.
- **Busy rule.** i_5tuple_data_wr arriving outside IDLE_S is discarded, o_drop_err pulses, and the search in progress is unaffected. A request in the same cycle the FSM returns to IDLE_S is in IDLE_S, so it is accepted.

## Timing
- Reset values:
  - All outputs are 0.
  - Every table entry and every cache valid bit is 0.
  - wr_ptr is 0, idx is 0, state is IDLE_S.
  - A reset mid-search aborts the search with no o_lookup_wr.
- All outputs are registered. Request sampled in cycle 0:
  - Non-IP or non-TCP/UDP first fragment: o_lookup_wr in cycle 1.
  - Table hit at index k: o_lookup_wr in cycle k+2.
  - Table miss: o_lookup_wr in cycle ENTRY_NUM+1.
  - Cache hit at index j: o_lookup_wr in cycle j+2.
  - Cache miss: o_lookup_wr in cycle FRAG_NUM+1.
- ov_flow_id, o_hit and o_standardpkt_tsnpkt_flag change only with o_lookup_wr and hold until the next result.
- Worst case is 17 cycles, well under the extractor's 38+ cycle minimum request spacing.

## Structure
- Shared package map_pkg:
  - state encodings;
  - KEY_W=104;
  - FLOWID_W;
  - the five-tuple field offset constants.
- Sub-module map_frag_cache:
  - holds the FRAG_NUM {valid, id, flow_id} registers and wr_ptr;
  - write port, index read port, and a match output for the indexed entry.
- Match table is a register array inside map_lookup_match.

## Test plan
- Table entry 5 = {valid, key K, flow_id 0x123}; request K as a first fragment with TCP -> o_lookup_wr in cycle 7, o_hit=1, ov_flow_id=0x123.
- Request with an unknown key -> o_lookup_wr in cycle 17, o_hit=0, ov_flow_id=0.
- After the first test, request id 0x1A2B with i_first_fragment=1 and key K, then a non-first fragment with id 0x1A2B -> hit, flow 0x123, o_lookup_wr in cycle 2. A non-first fragment with id 0x0001 -> miss in cycle 5.
- Five first-fragment hits with ids 1..5, then a non-first fragment with id 1 -> miss (slot overwritten on wrap); non-first fragment with id 5 -> hit.
- i_ip_flag=0 -> miss in cycle 1. A second request in cycle 3 of a table search -> o_drop_err pulse, and the first result is unchanged.
- Invalidate entry 5 in the cycle its search index compares it -> hit still reported (old contents); an identical repeat request -> miss. Assert reset mid-search -> no strobe, and all outputs read 0.

Source files
------------

// File: rtl/map_pkg.sv
// map_pkg: shared lookup FSM encodings, widths and five-tuple field offsets.
package map_pkg;
    localparam int KEY_W     = 104;
    localparam int FLOWID_W  = 14;
    localparam int ID_W      = 16;
    localparam int PROTO_LSB = 96;
    localparam int SIP_LSB   = 64;
    localparam int DIP_LSB   = 32;
    localparam int SPORT_LSB = 16;
    localparam int DPORT_LSB = 0;
    typedef enum logic [1:0] {IDLE_S, SEARCH_S, FRAG_SEARCH_S} state_t;
endpackage

// File: rtl/map_frag_cache.sv
// map_frag_cache: round-robin cache of {valid, identification, flow_id} for non-first fragments.
module map_frag_cache #(
    parameter int FRAG_NUM = 4,
    parameter int FLOWID_W = 14,
    parameter int IDX_W    = $clog2(FRAG_NUM)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wr,
    input  logic [15:0]         iv_wid,
    input  logic [FLOWID_W-1:0] iv_wflow,
    input  logic [IDX_W-1:0]    iv_ridx,
    input  logic [15:0]         iv_cmp_id,
    output logic                o_match,
    output logic [FLOWID_W-1:0] ov_flow_id
);
    logic [FRAG_NUM-1:0] valid_q;
    logic [15:0]         id_q   [FRAG_NUM];
    logic [FLOWID_W-1:0] flow_q [FRAG_NUM];
    logic [IDX_W-1:0]    wr_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            wr_ptr  <= '0;
            for (int i = 0; i < FRAG_NUM; i++) begin
                id_q[i]   <= '0;
                flow_q[i] <= '0;
            end
        end else if (i_wr) begin
            valid_q[wr_ptr] <= 1'b1;
            id_q[wr_ptr]    <= iv_wid;
            flow_q[wr_ptr]  <= iv_wflow;
            wr_ptr          <= wr_ptr + 1'b1;
        end
    end

    assign o_match    = valid_q[iv_ridx] && (id_q[iv_ridx] == iv_cmp_id);
    assign ov_flow_id = flow_q[iv_ridx];
endmodule

// File: rtl/map_lookup_match.sv
// map_lookup_match: sequential match-table search for first fragments, fragment-cache search for the rest.
module map_lookup_match #(
    parameter int ENTRY_NUM = 16,
    parameter int ADDR_W    = 4,
    parameter int FRAG_NUM  = 4,
    parameter int FLOWID_W  = 14
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [map_pkg::KEY_W-1:0]           iv_5tuple_data,
    input  logic                                i_5tuple_data_wr,
    input  logic [15:0]                         iv_identification,
    input  logic                                i_first_fragment,
    input  logic                                i_ip_flag,
    input  logic                                i_tcp_or_udp_flag,
    input  logic                                i_standardpkt_tsnpkt_flag,
    input  logic                                i_table_wr,
    input  logic [ADDR_W-1:0]                   iv_table_waddr,
    input  logic [map_pkg::KEY_W+FLOWID_W:0]    iv_table_wdata,
    output logic [FLOWID_W-1:0]                 ov_flow_id,
    output logic                                o_hit,
    output logic                                o_lookup_wr,
    output logic                                o_standardpkt_tsnpkt_flag,
    output logic                                o_drop_err
);
    import map_pkg::*;
    localparam int EW     = KEY_W + FLOWID_W + 1;
    localparam int FIDX_W = $clog2(FRAG_NUM);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [KEY_W-1:0]    key_q;
    logic [15:0]         id_q;
    logic                flag_q;
    logic [EW-1:0]       table_q [ENTRY_NUM];
    logic [EW-1:0]       entry;
    logic                tbl_match, frag_match, accept, done, hit_d, cache_wr;
    logic [FLOWID_W-1:0] flow_d, frag_flow;

    assign entry     = table_q[idx_q];
    assign tbl_match = entry[EW-1] && (entry[FLOWID_W +: KEY_W] == key_q);

    map_frag_cache #(.FRAG_NUM(FRAG_NUM), .FLOWID_W(FLOWID_W)) u_cache (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr       (cache_wr),
        .iv_wid     (id_q),
        .iv_wflow   (entry[FLOWID_W-1:0]),
        .iv_ridx    (idx_q[FIDX_W-1:0]),
        .iv_cmp_id  (id_q),
        .o_match    (frag_match),
        .ov_flow_id (frag_flow)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        accept   = 1'b0;
        done     = 1'b0;
        hit_d    = 1'b0;
        flow_d   = '0;
        cache_wr = 1'b0;
        case (state_q)
            IDLE_S: if (i_5tuple_data_wr) begin
                accept = 1'b1;
                idx_d  = '0;
                if (!i_ip_flag || (i_first_fragment && !i_tcp_or_udp_flag))
                    done = 1'b1;
                else
                    state_d = i_first_fragment ? SEARCH_S : FRAG_SEARCH_S;
            end
            SEARCH_S: begin
                if (tbl_match || idx_q == ADDR_W'(ENTRY_NUM - 1)) begin
                    done     = 1'b1;
                    hit_d    = tbl_match;
                    flow_d   = tbl_match ? entry[FLOWID_W-1:0] : '0;
                    cache_wr = tbl_match;
                    state_d  = IDLE_S;
                end else
                    idx_d = idx_q + 1'b1;
            end
            FRAG_SEARCH_S: begin
                if (frag_match || idx_q == ADDR_W'(FRAG_NUM - 1)) begin
                    done    = 1'b1;
                    hit_d   = frag_match;
                    flow_d  = frag_match ? frag_flow : '0;
                    state_d = IDLE_S;
                end else
                    idx_d = idx_q + 1'b1;
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q                   <= IDLE_S;
            idx_q                     <= '0;
            key_q                     <= '0;
            id_q                      <= '0;
            flag_q                    <= 1'b0;
            ov_flow_id                <= '0;
            o_hit                     <= 1'b0;
            o_lookup_wr               <= 1'b0;
            o_standardpkt_tsnpkt_flag <= 1'b0;
            o_drop_err                <= 1'b0;
            for (int i = 0; i < ENTRY_NUM; i++)
                table_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            o_lookup_wr <= done;
            o_drop_err  <= i_5tuple_data_wr && (state_q != IDLE_S);
            if (accept) begin
                key_q  <= iv_5tuple_data;
                id_q   <= iv_identification;
                flag_q <= i_standardpkt_tsnpkt_flag;
            end
            // the direct-miss path reports in the accept cycle, so take the flag straight from the input
            if (done) begin
                ov_flow_id                <= flow_d;
                o_hit                     <= hit_d;
                o_standardpkt_tsnpkt_flag <= accept ? i_standardpkt_tsnpkt_flag : flag_q;
            end
            if (i_table_wr)
                table_q[iv_table_waddr] <= iv_table_wdata;
        end
    end
endmodule

// File: tb/tb_map_lookup_match.sv
// tb_map_lookup_match: randomized scoreboard bench with an array-based reference model.
module tb_map_lookup_match;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [103:0] data = '0;
    logic         dwr = 1'b0;
    logic [15:0]  id = '0;
    logic         first = 1'b0, ip = 1'b0, tcp = 1'b0, sflag = 1'b0;
    logic         twr = 1'b0;
    logic [3:0]   twaddr = '0;
    logic [118:0] twdata = '0;
    logic [13:0]  ov_flow_id;
    logic         o_hit, o_lookup_wr, o_sflag, o_drop_err;

    map_lookup_match dut (
        .i_clk(clk), .i_rst_n(rst_n), .iv_5tuple_data(data), .i_5tuple_data_wr(dwr),
        .iv_identification(id), .i_first_fragment(first), .i_ip_flag(ip),
        .i_tcp_or_udp_flag(tcp), .i_standardpkt_tsnpkt_flag(sflag), .i_table_wr(twr),
        .iv_table_waddr(twaddr), .iv_table_wdata(twdata), .ov_flow_id(ov_flow_id),
        .o_hit(o_hit), .o_lookup_wr(o_lookup_wr), .o_standardpkt_tsnpkt_flag(o_sflag),
        .o_drop_err(o_drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {bit hit; logic [13:0] flow; bit flag; int cyc;} exp_t;
    exp_t exp_q[$];
    int   drop_q[$];
    exp_t mon_e;
    int   total = 0, bad = 0, cyc = 0, strobes = 0;

    bit          m_v[16];
    logic [103:0] m_k[16];
    logic [13:0] m_f[16];
    bit          c_v[4];
    logic [15:0] c_id[4];
    logic [13:0] c_f[4];
    int          wp = 0;
    logic [103:0] pool[16];

    localparam logic [103:0] K = 104'h06_C0A80001_C0A80002_1234_0050;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) if (rst_n) begin
        if (o_lookup_wr) begin
            strobes++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_strobe got=strobe want=none (cyc %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("hit", o_hit, mon_e.hit);
                chk("flow", ov_flow_id, mon_e.flow);
                chk("flag", o_sflag, mon_e.flag);
                chk("latency_cycle", cyc, mon_e.cyc);
            end
        end
        if (o_drop_err) begin
            if (drop_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_drop got=pulse want=none (cyc %0d)", cyc);
            end else
                chk("drop_cycle", cyc, drop_q.pop_front());
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin m_v[i] = 0; m_k[i] = '0; m_f[i] = '0; end
        for (int i = 0; i < 4; i++) begin c_v[i] = 0; c_id[i] = '0; c_f[i] = '0; end
        wp = 0;
    endfunction

    // reference: lowest matching index wins; latency = 2 + index scanned, or full scan + 1
    function automatic exp_t predict(logic [103:0] k, logic [15:0] i_d, bit f, bit p, bit t, bit fl);
        exp_t e;
        e.hit = 0; e.flow = '0; e.flag = fl;
        if (!p || (f && !t)) begin
            e.cyc = cyc + 1;
            return e;
        end
        if (f) begin
            e.cyc = cyc + 17;
            for (int n = 0; n < 16; n++) if (m_v[n] && m_k[n] == k) begin
                e.hit = 1; e.flow = m_f[n]; e.cyc = cyc + n + 2;
                c_v[wp] = 1; c_id[wp] = i_d; c_f[wp] = m_f[n]; wp = (wp + 1) % 4;
                break;
            end
        end else begin
            e.cyc = cyc + 5;
            for (int n = 0; n < 4; n++) if (c_v[n] && c_id[n] == i_d) begin
                e.hit = 1; e.flow = c_f[n]; e.cyc = cyc + n + 2;
                break;
            end
        end
        return e;
    endfunction

    task automatic tbl_write(input int a, input bit v, input logic [103:0] k, input logic [13:0] f);
        twr = 1; twaddr = a[3:0]; twdata = {v, k, f};
        m_v[a] = v; m_k[a] = k; m_f[a] = f;
        @(negedge clk);
        twr = 0;
    endtask

    task automatic req(input logic [103:0] k, input logic [15:0] i_d, input bit f, input bit p,
                       input bit t, input bit fl, input bit drop);
        data = k; id = i_d; first = f; ip = p; tcp = t; sflag = fl; dwr = 1;
        if (drop) drop_q.push_back(cyc + 1);
        else exp_q.push_back(predict(k, i_d, f, p, t, fl));
        @(negedge clk);
        dwr = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && (exp_q.size() != 0 || drop_q.size() != 0); i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0 || drop_q.size() != 0) begin
            bad++;
            $display("FAIL timeout got=%0d_pending want=0", exp_q.size() + drop_q.size());
            exp_q.delete(); drop_q.delete();
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_flow", ov_flow_id, 0);
        chk("rst_hit", o_hit, 0);
        chk("rst_wr", o_lookup_wr, 0);
        chk("rst_flag", o_sflag, 0);
        chk("rst_drop", o_drop_err, 0);

        tbl_write(5, 1, K, 14'h123);
        req(K, 16'h1A2B, 1, 1, 1, 1, 0); wait_idle();
        req(104'hDEAD, 16'h0, 1, 1, 1, 0, 0); wait_idle();
        req(K, 16'h1A2B, 1, 1, 1, 0, 0); wait_idle();
        req(104'h0, 16'h1A2B, 0, 1, 1, 1, 0); wait_idle();
        req(104'h0, 16'h0001, 0, 1, 0, 0, 0); wait_idle();
        for (int n = 1; n <= 5; n++) begin req(K, 16'(n), 1, 1, 1, 0, 0); wait_idle(); end
        req(104'h0, 16'h0001, 0, 1, 1, 0, 0); wait_idle();
        req(104'h0, 16'h0005, 0, 1, 1, 1, 0); wait_idle();
        req(K, 16'h0, 1, 0, 1, 1, 0); wait_idle();
        req(K, 16'h0, 1, 1, 0, 0, 0); wait_idle();

        req(K, 16'h7, 1, 1, 1, 1, 0);
        repeat (2) @(negedge clk);
        req(104'hBEEF, 16'h0, 1, 1, 1, 0, 1);
        wait_idle();

        req(K, 16'h9, 1, 1, 1, 0, 0);
        repeat (5) @(negedge clk);
        tbl_write(5, 0, K, 14'h123);
        wait_idle();
        req(K, 16'h9, 1, 1, 1, 0, 0); wait_idle();

        for (int n = 0; n < 16; n++) pool[n] = {$urandom, $urandom, $urandom, 8'($urandom)};
        for (int n = 0; n < 16; n++) tbl_write(n, ($urandom_range(0, 3) != 0), pool[$urandom_range(0, 15)], 14'($urandom));
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0)
                tbl_write($urandom_range(0, 15), $urandom_range(0, 1), pool[$urandom_range(0, 15)], 14'($urandom));
            req(($urandom_range(0, 4) == 0) ? {$urandom, $urandom, $urandom, 8'($urandom)} : pool[$urandom_range(0, 15)],
                16'($urandom_range(1, 6)), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 9) != 0), $urandom_range(0, 1), 0);
            wait_idle();
        end

        tbl_write(3, 1, K, 14'h2AA);
        req(104'hFACE, 16'h0, 1, 1, 1, 1, 0);
        repeat (5) @(negedge clk);
        rst_n = 0;
        exp_q.delete();
        model_reset();
        begin
            int s0;
            s0 = strobes;
            repeat (2) @(negedge clk);
            chk("rst_mid_flow", ov_flow_id, 0);
            chk("rst_mid_hit", o_hit, 0);
            chk("rst_mid_flag", o_sflag, 0);
            rst_n = 1;
            repeat (20) @(negedge clk);
            chk("rst_mid_no_strobe", strobes, s0);
        end
        req(K, 16'h0, 1, 1, 1, 0, 0); wait_idle();
        req(104'h0, 16'h1A2B, 0, 1, 1, 0, 0); wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
